// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative signed multiply (radix-2 Booth) / divide (restoring)
//             unit with HI/LO result registers. Optional macro:
//             MDU_DIV0_CHECK_EN (early divide-by-zero exit with div0 flag).
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_MULT = 2'd1;
   localparam logic [1:0] c_DIV  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator / divide remainder
   logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend-quotient
   logic [WIDTH-1:0] m_q, m_d;         // multiplicand / divisor magnitude
   logic             qm1_q, qm1_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH:0]   w_m_ext;
   logic [WIDTH:0]   w_booth_sum;
   logic [WIDTH:0]   w_booth_acc;
   logic [WIDTH-1:0] w_booth_mq;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH:0]   w_div_diff;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_last;

`ifdef MDU_DIV0_CHECK_EN
   logic             div0_q, div0_d;
`endif

   always_comb begin
      w_m_ext = {m_q[WIDTH-1], m_q};
      case ({mq_q[0], qm1_q})
         2'b01:   w_booth_sum = acc_q + w_m_ext;
         2'b10:   w_booth_sum = acc_q - w_m_ext;
         default: w_booth_sum = acc_q;
      endcase
      w_booth_acc = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
      w_booth_mq  = {w_booth_sum[0], mq_q[WIDTH-1:1]};

      // Restoring step: remainder and divisor are both unsigned magnitudes.
      w_div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
      w_div_diff  = w_div_shift - {1'b0, m_q};
      if (!w_div_diff[WIDTH]) begin
         w_rem = w_div_diff[WIDTH-1:0];
         w_quo = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
         w_rem = w_div_shift[WIDTH-1:0];
         w_quo = {mq_q[WIDTH-2:0], 1'b0};
      end

      w_abs_a = a[WIDTH-1] ? -a : a;
      w_abs_b = b[WIDTH-1] ? -b : b;
      w_last  = (cnt_q == CNT_W'(WIDTH-1));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      m_d     = m_q;
      qm1_d   = qm1_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MDU_DIV0_CHECK_EN
      div0_d  = div0_q;
`endif
      case (state_q)
         c_IDLE: begin
            if (start) begin
               cnt_d = '0;
               acc_d = '0;
               qm1_d = 1'b0;
               if (!op) begin
                  state_d = c_MULT;
                  mq_d    = a;
                  m_d     = b;
               end else begin
                  state_d = c_DIV;
                  mq_d    = w_abs_a;
                  m_d     = w_abs_b;
                  qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                  rneg_d  = a[WIDTH-1];
               end
            end
         end
         c_MULT: begin
            acc_d = w_booth_acc;
            mq_d  = w_booth_mq;
            qm1_d = mq_q[0];
            cnt_d = cnt_q + 1'b1;
            if (w_last) begin
               state_d = c_DONE;
               hi_d    = w_booth_acc[WIDTH-1:0];
               lo_d    = w_booth_mq;
`ifdef MDU_DIV0_CHECK_EN
               div0_d  = 1'b0;
`endif
            end
         end
         c_DIV: begin
`ifdef MDU_DIV0_CHECK_EN
            if (m_q == '0) begin
               state_d = c_DONE;
               div0_d  = 1'b1;
            end else
`endif
            begin
               acc_d = {1'b0, w_rem};
               mq_d  = w_quo;
               cnt_d = cnt_q + 1'b1;
               // Sign fix-up folded into the final register write.
               if (w_last) begin
                  state_d = c_DONE;
                  hi_d    = rneg_q ? -w_rem : w_rem;
                  lo_d    = qneg_q ? -w_quo : w_quo;
`ifdef MDU_DIV0_CHECK_EN
                  div0_d  = 1'b0;
`endif
               end
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= c_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         m_q     <= '0;
         qm1_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         m_q     <= m_d;
         qm1_q   <= qm1_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

`ifdef MDU_DIV0_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         div0_q <= 1'b0;
      end else begin
         div0_q <= div0_d;
      end
   end
   assign div0 = div0_q;
`else
   assign div0 = 1'b0;
`endif

   assign busy = (state_q != c_IDLE);
   assign done = (state_q == c_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Directed vector bench for mult_div_unit (MULT/DIV, latency,
//             divide-by-zero, start-while-busy, mid-operation reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div0;

   int checks   = 0;
   int failures = 0;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .div0  (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Issue one op and wait for done; lat counts cycles from acceptance.
   task automatic do_op(input logic o, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int busy_bad);
      @(negedge clk);
      start = 1'b1; op = o; a = aa; b = bb;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_bad = 0;
      while (!done && lat < 100) begin
         if (!busy) busy_bad++;
         @(negedge clk);
         lat++;
      end
      if (!busy) busy_bad++;
   endtask

   initial begin
      int lat;
      int bb;
      int ndone;

      vecs[0]  = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000};
      vecs[2]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[3]  = '{1'b0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      vecs[4]  = '{1'b0, 32'h12345678,   32'h00000000, 32'h00000000, 32'h00000000};
      vecs[5]  = '{1'b0, 32'h80000000,   32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
      vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[7]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[8]  = '{1'b1, 32'd100,        32'd7,        32'd2,        32'd14};
      vecs[9]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
      vecs[11] = '{1'b1, 32'd3,          32'd10,       32'd3,        32'd0};
      vecs[12] = '{1'b1, 32'h7FFFFFFF,   32'd1,        32'd0,        32'h7FFFFFFF};
      vecs[13] = '{1'b1, 32'h80000000,   32'h80000000, 32'd0,        32'd1};

      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi",   64'(hi),   64'd0);
      chk("reset_lo",   64'(lo),   64'd0);
      chk("reset_div0", 64'(div0), 64'd0);

      for (int i = 0; i < 14; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bb);
         chk($sformatf("v%0d_latency", i), 64'(lat),  64'd33);
         chk($sformatf("v%0d_busy", i),    64'(bb),   64'd0);
         chk($sformatf("v%0d_hi", i),      64'(hi),   64'(vecs[i].hi));
         chk($sformatf("v%0d_lo", i),      64'(lo),   64'(vecs[i].lo));
         chk($sformatf("v%0d_div0", i),    64'(div0), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i),   64'({done, busy}), 64'd0);
      end

      // Divide by zero; previous result is hi=0, lo=1.
`ifdef MDU_DIV0_CHECK_EN
      do_op(1'b1, 32'd5, 32'd0, lat, bb);
      chk("div0_latency", 64'(lat),  64'd2);
      chk("div0_flag",    64'(div0), 64'd1);
      chk("div0_hi",      64'(hi),   64'd0);
      chk("div0_lo",      64'(lo),   64'd1);
`else
      do_op(1'b1, 32'd5, 32'd0, lat, bb);
      chk("div0_latency", 64'(lat),  64'd33);
      chk("div0_flag",    64'(div0), 64'd0);
      chk("div0_hi",      64'(hi),   64'd5);
      chk("div0_lo",      64'(lo),   64'hFFFFFFFF);
      do_op(1'b1, 32'hFFFFFFFB, 32'd0, lat, bb);
      chk("div0n_hi",     64'(hi),   64'hFFFFFFFB);
      chk("div0n_lo",     64'(lo),   64'd1);
`endif
      do_op(1'b0, 32'd2, 32'd3, lat, bb);
      chk("post_div0_flag", 64'(div0), 64'd0);
      chk("post_div0_lo",   64'(lo),   64'd6);

      // Start pulsed mid-MULT must be ignored; start right after done accepted.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      repeat (4) begin @(negedge clk); lat++; end
      start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd2;
      @(negedge clk);
      lat++;
      start = 1'b0;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      chk("ignore_latency", 64'(lat), 64'd33);
      chk("ignore_hi",      64'(hi),  64'd0);
      chk("ignore_lo",      64'(lo),  64'd12);
      @(negedge clk);
      chk("ignore_one_done", 64'({done, busy}), 64'd0);
      start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accepted", 64'(busy), 64'd1);
      lat = 1;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      chk("b2b_latency", 64'(lat), 64'd33);
      chk("b2b_hi",      64'(hi),  64'd1);
      chk("b2b_lo",      64'(lo),  64'd4);

      // Reset ten cycles into a DIV aborts it and clears hi/lo.
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi",   64'(hi),   64'd0);
      chk("abort_lo",   64'(lo),   64'd0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
